// File: rtl/imm_extend_pipe_pkg.sv
// Shared package for the immediate extender pipe: mode encodings and
// default datapath widths.
package imm_ext_pkg;

  localparam int IMM_IN_W_DEF  = 8;
  localparam int IMM_OUT_W_DEF = 16;

  typedef enum logic [1:0] {
    IMM_ZERO  = 2'b00,
    IMM_SIGN  = 2'b01,
    IMM_UPPER = 2'b10,
    IMM_RSVD  = 2'b11
  } imm_mode_e;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Valid/ready bundle for imm_extend_pipe: request side (in_*) and
// result side (out_*). slave = the block, master = its environment.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/imm_extend_pipe_core.sv
// imm_ext_core: combinational immediate extension.
// in_imm/in_mode -> data (OUT_W), err (reserved mode).
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W_DEF,
  parameter int OUT_W = IMM_OUT_W_DEF
) (
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic [OUT_W-1:0] data,
  output logic             err
);

  always_comb begin
    data = '0;
    err  = 1'b0;
    unique case (1'b1)
      (in_mode == IMM_ZERO):
        data = OUT_W'(in_imm);
      (in_mode == IMM_SIGN):
        data = OUT_W'($signed(in_imm));
      (in_mode == IMM_UPPER):
        data = OUT_W'(in_imm) << (OUT_W - IN_W);
      (in_mode == IMM_RSVD):
        err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender with a 2-entry FIFO skid buffer (1-cycle latency).
// Ports: clk, rst (sync, active-high), bus (imm_extend_pipe_if.slave),
// neg_count[15:0] only when IMMEXT_STATS_EN is defined.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W_DEF,
  parameter int OUT_W = IMM_OUT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  imm_extend_pipe_if.slave bus
`ifdef IMMEXT_STATS_EN
  ,
  output logic [15:0] neg_count
`endif
);

  if (IN_W > OUT_W) begin : g_bad_w
    $error("imm_extend_pipe: IN_W must not exceed OUT_W");
  end

  logic [OUT_W-1:0] ext_data;
  logic             ext_err;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_imm  (bus.in_imm),
    .in_mode (bus.in_mode),
    .data    (ext_data),
    .err     (ext_err)
  );

  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [OUT_W-1:0] data_q [2];
  logic             err_q  [2];
  logic             push;
  logic             pop;

  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = data_q[rd_ptr];
  assign bus.out_err   = err_q[rd_ptr];

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      err_q[0]  <= 1'b0;
      err_q[1]  <= 1'b0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= ext_data;
        err_q[wr_ptr]  <= ext_err;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef IMMEXT_STATS_EN
  logic [1:0] mode_q [2];
  logic       head_neg;

  assign head_neg = (mode_q[rd_ptr] == IMM_SIGN) &&
                    data_q[rd_ptr][IN_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q[0] <= 2'b00;
      mode_q[1] <= 2'b00;
      neg_count <= 16'd0;
    end else begin
      if (push)
        mode_q[wr_ptr] <= bus.in_mode;
      if (pop && head_neg && neg_count != 16'hFFFF)
        neg_count <= neg_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (default widths).
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_imm_extend_pipe;
  import imm_ext_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  imm_extend_pipe_if #(.IN_W(8), .OUT_W(16)) bus ();

`ifdef IMMEXT_STATS_EN
  logic [15:0] neg_count;
`endif

  imm_extend_pipe #(.IN_W(8), .OUT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef IMMEXT_STATS_EN
    ,
    .neg_count (neg_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m,
                       input logic [7:0] imm);
    bus.in_valid = v;
    bus.in_mode  = m;
    bus.in_imm   = imm;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    drive(1'b0, IMM_ZERO, 8'h00);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    checks++;
    if (bus.out_data !== 16'h0000 || bus.out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_data got=%h/%b want=0000/0",
               bus.out_data, bus.out_err);
    end
`ifdef IMMEXT_STATS_EN
    checks++;
    if (neg_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_neg_count got=%0d want=0", neg_count);
    end
`endif
  endtask

  task automatic test_modes();
    logic [1:0]  m   [5] = '{IMM_SIGN, IMM_ZERO, IMM_UPPER,
                             IMM_RSVD, IMM_SIGN};
    logic [7:0]  imm [5] = '{8'h85, 8'h85, 8'hA5, 8'h7F, 8'h7F};
    logic [15:0] exp [5] = '{16'hFF85, 16'h0085, 16'hA500,
                             16'h0000, 16'h007F};
    logic        ee  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, m[i], imm[i]);
      step();
      drive(1'b0, IMM_ZERO, 8'h00);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i] ||
          bus.out_err !== ee[i]) begin
        errors++;
        $display("FAIL mode_%0d got=%b/%h/%b want=1/%h/%b", i,
                 bus.out_valid, bus.out_data, bus.out_err,
                 exp[i], ee[i]);
      end
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mode_%0d_drain got=%b want=0", i,
                 bus.out_valid);
      end
    end
  endtask

  task automatic test_full();
    bus.out_ready = 1'b0;
    drive(1'b1, IMM_SIGN, 8'h01);
    step();
    drive(1'b1, IMM_SIGN, 8'h02);
    step();
    drive(1'b1, IMM_SIGN, 8'h03);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_in_ready got=%b want=0", bus.in_ready);
    end
    step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_data !== 16'h0001) begin
      errors++;
      $display("FAIL full_hold got=%b/%h want=0/0001",
               bus.in_ready, bus.out_data);
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_data !== 16'h0002 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop1 got=%h/%b want=0002/1",
               bus.out_data, bus.in_ready);
    end
    step();
    drive(1'b0, IMM_ZERO, 8'h00);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0003) begin
      errors++;
      $display("FAIL full_pop2 got=%b/%h want=1/0003",
               bus.out_valid, bus.out_data);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_drain got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    drive(1'b1, IMM_ZERO, 8'h10);
    step();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, IMM_ZERO, 8'(8'h11 + i));
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 ||
          bus.out_data !== 16'(16'h0010 + i)) begin
        errors++;
        $display("FAIL b2b_%0d got=%b/%b/%h want=1/1/%h", i,
                 bus.out_valid, bus.in_ready, bus.out_data,
                 16'(16'h0010 + i));
      end
      step();
    end
    drive(1'b0, IMM_ZERO, 8'h00);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h001A) begin
      errors++;
      $display("FAIL b2b_last got=%b/%h want=1/001a",
               bus.out_valid, bus.out_data);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_reset_full();
`ifdef IMMEXT_STATS_EN
    checks++;
    if (neg_count !== 16'd1) begin
      errors++;
      $display("FAIL stats_before got=%0d want=1", neg_count);
    end
`endif
    bus.out_ready = 1'b0;
    drive(1'b1, IMM_SIGN, 8'h80);
    step();
    drive(1'b1, IMM_SIGN, 8'h81);
    step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_data !== 16'hFF80) begin
      errors++;
      $display("FAIL rfull_setup got=%b/%h want=0/ff80",
               bus.in_ready, bus.out_data);
    end
    drive(1'b1, IMM_SIGN, 8'h55);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rfull_pre got=%b want=0", bus.in_ready);
    end
    step();
    rst = 1'b0;
    drive(1'b0, IMM_ZERO, 8'h00);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_data !== 16'h0000 || bus.out_err !== 1'b0) begin
      errors++;
      $display("FAIL rfull_after got=%b/%b/%h/%b want=0/1/0000/0",
               bus.out_valid, bus.in_ready, bus.out_data,
               bus.out_err);
    end
`ifdef IMMEXT_STATS_EN
    checks++;
    if (neg_count !== 16'd0) begin
      errors++;
      $display("FAIL rfull_neg got=%0d want=0", neg_count);
    end
`endif
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000) begin
      errors++;
      $display("FAIL rfull_stale got=%b/%h want=0/0000",
               bus.out_valid, bus.out_data);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mode   = IMM_ZERO;
    bus.in_imm    = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_modes();
    test_full();
    test_back_to_back();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
